hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL, default 1, meaning load-use stall length in cycles (legal 1..3).
REQ-002 SHALL have parameter NOP_ADDR_W, default 32, meaning width of the redirect target and npc_o.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous active-high reset, sampled on the rising edge of clk_i.
REQ-005 SHALL have ports id_rs1_i, id_rs2_i  input  5  source register numbers of the instruction in ID.
REQ-006 SHALL have ports id_rs1_used_i, id_rs2_used_i  input  1  the ID instruction reads rs1 / rs2.
REQ-007 SHALL have ports ex_valid_i, ex_mem_read_i  input  1  EX holds a real instruction / that instruction is a load.
REQ-008 SHALL have port ex_rd_i  input  5  destination register of the EX instruction.
REQ-009 SHALL have ports ex_redirect_i (input, 1) and ex_target_i (input, NOP_ADDR_W): taken branch/jump resolved in EX, and its target.
REQ-010 SHALL have port mem_busy_i  input  1  data memory not ready; the MEM stage must hold.
REQ-011 SHALL have ports data_suspend_o, flush_o (output, 1) and npc_o (output, NOP_ADDR_W), driving the PC register's data_suspend_i, flush_i and npc_i.
REQ-012 SHALL have ports ifid_hold_o, ifid_flush_o, idex_bubble_o, pipe_hold_o  output  1  hold/flush IF/ID, insert bubble into ID/EX, freeze EX/MEM/WB.

Function
REQ-013 SHALL define load-use hazard LU = ex_valid_i & ex_mem_read_i & ex_rd_i!=0 & ((id_rs1_used_i & id_rs1_i==ex_rd_i) | (id_rs2_used_i & id_rs2_i==ex_rd_i)).
REQ-014 SHALL implement FSM states RUN, LU_STALL and MEM_WAIT, plus a pending-redirect register (pend_v, pend_tgt).
REQ-015 In RUN with mem_busy_i=0 and ex_redirect_i=1: flush_o=1, npc_o=ex_target_i, ifid_flush_o=1, idex_bubble_o=1, combinationally in the same cycle; next state RUN.
REQ-016 In RUN with mem_busy_i=0, ex_redirect_i=0 and LU=1: data_suspend_o=1, ifid_hold_o=1, idex_bubble_o=1; when LU_STALL>1, load counter with LU_STALL-1 and enter LU_STALL; otherwise stay in RUN.
REQ-017 In LU_STALL: assert the same outputs as REQ-016 and decrement the counter; return to RUN on the cycle the counter reads 0 (total stall = LU_STALL cycles).
REQ-018 From any state, mem_busy_i=1 SHALL enter or stay in MEM_WAIT with data_suspend_o=1, ifid_hold_o=1, pipe_hold_o=1, flush_o=0.
REQ-019 ex_redirect_i=1 while mem_busy_i=1 SHALL set pend_v=1 and pend_tgt=ex_target_i, keeping the first target until it is consumed.
REQ-020 On the first cycle with mem_busy_i=0 in MEM_WAIT: if pend_v, flush_o=1, npc_o=pend_tgt, ifid_flush_o=1 and idex_bubble_o=1, clearing pend_v; else all outputs deasserted; next state RUN.
REQ-021 Priority: mem_busy_i > pending redirect > ex_redirect_i > LU, and flush_o=1 SHALL never coincide with data_suspend_o=1.
REQ-022 Redirect during LU_STALL SHALL abort the stall (counter cleared, state RUN); this cannot occur legally but must be deterministic.
REQ-023 npc_o SHALL equal ex_target_i whenever flush_o=0; there is no other arithmetic, and the counter width is 2 bits.

Reset
REQ-024 reset_i=1 at a clock edge SHALL force state RUN, counter 0, pend_v=0 and pend_tgt=0, including mid-stall or mid-MEM_WAIT.
REQ-025 During and after reset with all inputs 0, every 1-bit output SHALL be 0.

Structure
REQ-026 The state encoding (RUN=0, LU_STALL=1, MEM_WAIT=2) and the register-number width of 5 SHALL live in the shared CPU package.
REQ-027 Single module; no sub-module is required, and LU detection may sit in a local combinational block.

Verification
REQ-028 Load x5 in EX and ID reads x5 via rs2, LU_STALL=1 -> data_suspend_o=1 and idex_bubble_o=1 for exactly 1 cycle.
REQ-029 Same with LU_STALL=3 -> suspend held 3 cycles, then 0; same with ex_rd_i=0 -> no suspend.
REQ-030 ex_redirect_i=1 with ex_target_i=0x00000040 -> same cycle: flush_o=1, npc_o=0x40, ifid_flush_o=1.
REQ-031 mem_busy_i=1 for 4 cycles with redirect 0x80 in cycle 2 and 0x90 in cycle 3 -> suspend for 4 cycles, then one flush_o with npc_o=0x80.
REQ-032 reset_i=1 in cycle 2 of LU_STALL (LU_STALL=3) -> next cycle all outputs 0 and state RUN.
REQ-033 Random stimulus -> assertion that flush_o & data_suspend_o is never 1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared CPU definitions used by the hazard controller
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LU_STALL = 2'd1,
    S_MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: load-use stall, memory wait, redirect flush
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LU_STALL   = 1,
  parameter int NOP_ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [REG_W-1:0]      id_rs1_i,
  input  logic [REG_W-1:0]      id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_W-1:0]      ex_rd_i,
  input  logic                  ex_redirect_i,
  input  logic [NOP_ADDR_W-1:0] ex_target_i,
  input  logic                  mem_busy_i,
  output logic                  data_suspend_o,
  output logic                  flush_o,
  output logic [NOP_ADDR_W-1:0] npc_o,
  output logic                  ifid_hold_o,
  output logic                  ifid_flush_o,
  output logic                  idex_bubble_o,
  output logic                  pipe_hold_o
);

  localparam logic [1:0] LU_RELOAD = 2'(LU_STALL - 1);

  hz_state_e             state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pend_v_q, pend_v_d;
  logic [NOP_ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic                  lu_hit;

  always_comb begin
    lu_hit = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) &
             ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
              (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_v_d       = pend_v_q;
    pend_tgt_d     = pend_tgt_q;
    data_suspend_o = 1'b0;
    flush_o        = 1'b0;
    npc_o          = ex_target_i;
    ifid_hold_o    = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    pipe_hold_o    = 1'b0;

    if (mem_busy_i) begin
      // Whole pipe frozen; only the first redirect seen while frozen is kept.
      state_d        = S_MEM_WAIT;
      cnt_d          = '0;
      data_suspend_o = 1'b1;
      ifid_hold_o    = 1'b1;
      pipe_hold_o    = 1'b1;
      if (ex_redirect_i && !pend_v_q) begin
        pend_v_d   = 1'b1;
        pend_tgt_d = ex_target_i;
      end
    end else begin
      case (state_q)
        S_MEM_WAIT: begin
          state_d = S_RUN;
          if (pend_v_q) begin
            flush_o       = 1'b1;
            npc_o         = pend_tgt_q;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            pend_v_d      = 1'b0;
          end
        end
        S_LU_STALL: begin
          if (ex_redirect_i) begin
            flush_o       = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            cnt_d         = '0;
            state_d       = S_RUN;
          end else begin
            data_suspend_o = 1'b1;
            ifid_hold_o    = 1'b1;
            idex_bubble_o  = 1'b1;
            cnt_d          = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) state_d = S_RUN;
          end
        end
        default: begin
          if (ex_redirect_i) begin
            flush_o       = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
          end else if (lu_hit) begin
            data_suspend_o = 1'b1;
            ifid_hold_o    = 1'b1;
            idex_bubble_o  = 1'b1;
            if (LU_STALL > 1) begin
              cnt_d   = LU_RELOAD;
              state_d = S_LU_STALL;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl at stall lengths 1 and 3
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_rs1_used_i, id_rs2_used_i;
  logic        ex_valid_i, ex_mem_read_i, ex_redirect_i, mem_busy_i;
  logic [31:0] ex_target_i;

  logic        sus [2];
  logic        fl  [2];
  logic        ih  [2];
  logic        ifl [2];
  logic        bub [2];
  logic        ph  [2];
  logic [31:0] npc [2];

  int passed = 0;
  int total  = 0;

  // Reference state: remaining stall cycles, frozen flag, first pending redirect.
  int          lval [2] = '{1, 3};
  int          stall_left [2];
  bit          in_mw [2];
  bit          pv [2];
  logic [31:0] pt [2];

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.LU_STALL(1), .NOP_ADDR_W(32)) u_dut1 (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
    .ex_redirect_i(ex_redirect_i), .ex_target_i(ex_target_i), .mem_busy_i(mem_busy_i),
    .data_suspend_o(sus[0]), .flush_o(fl[0]), .npc_o(npc[0]),
    .ifid_hold_o(ih[0]), .ifid_flush_o(ifl[0]), .idex_bubble_o(bub[0]), .pipe_hold_o(ph[0])
  );

  hazard_ctrl #(.LU_STALL(3), .NOP_ADDR_W(32)) u_dut3 (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_valid_i(ex_valid_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i),
    .ex_redirect_i(ex_redirect_i), .ex_target_i(ex_target_i), .mem_busy_i(mem_busy_i),
    .data_suspend_o(sus[1]), .flush_o(fl[1]), .npc_o(npc[1]),
    .ifid_hold_o(ih[1]), .ifid_flush_o(ifl[1]), .idex_bubble_o(bub[1]), .pipe_hold_o(ph[1])
  );

  task automatic clear_inputs();
    reset_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; ex_rd_i = '0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0; ex_valid_i = 1'b0;
    ex_mem_read_i = 1'b0; ex_redirect_i = 1'b0; mem_busy_i = 1'b0; ex_target_i = '0;
  endtask

  // Compare both DUTs against the reference model, then advance one clock.
  task automatic cycle();
    #2;
    for (int d = 0; d < 2; d++) begin
      bit          lu;
      logic [5:0]  exp_v, got_v;
      logic [31:0] exp_npc;
      lu = ex_valid_i && ex_mem_read_i && (ex_rd_i != 0) &&
           ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
      exp_v   = '0;  // {suspend, flush, ifid_hold, ifid_flush, bubble, pipe_hold}
      exp_npc = ex_target_i;
      if (mem_busy_i) exp_v = 6'b101001;
      else if (in_mw[d]) begin
        if (pv[d]) begin exp_v = 6'b010110; exp_npc = pt[d]; end
      end
      else if (ex_redirect_i) exp_v = 6'b010110;
      else if (stall_left[d] > 0 || lu) exp_v = 6'b101010;
      got_v = {sus[d], fl[d], ih[d], ifl[d], bub[d], ph[d]};
      total++;
      if (got_v !== exp_v) $display("FAIL model_outputs dut%0d: got %b want %b", d, got_v, exp_v);
      else passed++;
      total++;
      if (npc[d] !== exp_npc) $display("FAIL model_npc dut%0d: got %h want %h", d, npc[d], exp_npc);
      else passed++;
      total++;
      if (fl[d] && sus[d]) $display("FAIL flush_and_suspend dut%0d: got 1 want 0", d);
      else passed++;
    end
    @(posedge clk_i);
    for (int d = 0; d < 2; d++) begin
      bit lu;
      lu = ex_valid_i && ex_mem_read_i && (ex_rd_i != 0) &&
           ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
      if (reset_i) begin
        stall_left[d] = 0; in_mw[d] = 0; pv[d] = 0; pt[d] = '0;
      end else if (mem_busy_i) begin
        in_mw[d] = 1; stall_left[d] = 0;
        if (ex_redirect_i && !pv[d]) begin pv[d] = 1; pt[d] = ex_target_i; end
      end else if (in_mw[d]) begin
        in_mw[d] = 0; pv[d] = 0;
      end else if (ex_redirect_i) stall_left[d] = 0;
      else if (stall_left[d] > 0) stall_left[d]--;
      else if (lu) stall_left[d] = lval[d] - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_i = 1'b1;
    for (int d = 0; d < 2; d++) begin stall_left[d] = 0; in_mw[d] = 0; pv[d] = 0; pt[d] = '0; end
    @(posedge clk_i); #1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({sus[d], fl[d], ih[d], ifl[d], bub[d], ph[d]} !== 6'b0)
        $display("FAIL reset_outputs dut%0d: got %b want 000000", d, {sus[d], fl[d], ih[d], ifl[d], bub[d], ph[d]});
      else passed++;
    end
    cycle();
    reset_i = 1'b0;
    cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_valid_i = 1; ex_mem_read_i = 1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_used_i = 1;
    #1;
    total++;
    if (!(sus[0] === 1 && bub[0] === 1 && sus[1] === 1))
      $display("FAIL lu_first_cycle: got sus1=%b bub1=%b sus3=%b want 1 1 1", sus[0], bub[0], sus[1]);
    else passed++;
    cycle();
    ex_valid_i = 0;
    for (int c = 1; c < 4; c++) begin
      #1;
      total++;
      if (sus[0] !== 1'b0) $display("FAIL lu1_len cycle%0d: got %b want 0", c, sus[0]);
      else passed++;
      total++;
      if (sus[1] !== (c < 3)) $display("FAIL lu3_len cycle%0d: got %b want %b", c, sus[1], (c < 3));
      else passed++;
      cycle();
    end
  endtask

  task automatic test_lu_x0();
    clear_inputs();
    ex_valid_i = 1; ex_mem_read_i = 1; ex_rd_i = 5'd0; id_rs2_i = 5'd0; id_rs2_used_i = 1;
    #1;
    total++;
    if (sus[0] !== 0 || sus[1] !== 0) $display("FAIL lu_x0: got %b%b want 00", sus[0], sus[1]);
    else passed++;
    cycle();
  endtask

  task automatic test_redirect();
    clear_inputs();
    ex_redirect_i = 1; ex_target_i = 32'h0000_0040;
    #1;
    total++;
    if (!(fl[0] === 1 && ifl[0] === 1 && npc[0] === 32'h40 && sus[0] === 0))
      $display("FAIL redirect: got flush=%b ifid_flush=%b npc=%h want 1 1 00000040", fl[0], ifl[0], npc[0]);
    else passed++;
    cycle();
    clear_inputs();
    cycle();
  endtask

  task automatic test_mem_busy();
    clear_inputs();
    mem_busy_i = 1;
    for (int c = 1; c <= 4; c++) begin
      ex_redirect_i = (c == 2 || c == 3);
      ex_target_i   = (c == 2) ? 32'h80 : (c == 3) ? 32'h90 : 32'h0;
      #1;
      total++;
      if (sus[1] !== 1 || fl[1] !== 0 || ph[1] !== 1)
        $display("FAIL mem_busy cycle%0d: got sus=%b flush=%b hold=%b want 1 0 1", c, sus[1], fl[1], ph[1]);
      else passed++;
      cycle();
    end
    clear_inputs();
    #1;
    total++;
    if (fl[1] !== 1 || npc[1] !== 32'h80)
      $display("FAIL mem_release: got flush=%b npc=%h want 1 00000080", fl[1], npc[1]);
    else passed++;
    cycle();
    #1;
    total++;
    if (fl[1] !== 0) $display("FAIL mem_single_flush: got %b want 0", fl[1]);
    else passed++;
    cycle();
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    ex_valid_i = 1; ex_mem_read_i = 1; ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs1_used_i = 1;
    cycle();
    clear_inputs();
    reset_i = 1;
    #1;
    total++;
    if (sus[1] !== 1) $display("FAIL stall_cycle2: got %b want 1", sus[1]);
    else passed++;
    cycle();
    reset_i = 0;
    #1;
    total++;
    if ({sus[1], fl[1], ih[1], ifl[1], bub[1], ph[1]} !== 6'b0)
      $display("FAIL reset_mid_stall: got %b want 000000", {sus[1], fl[1], ih[1], ifl[1], bub[1], ph[1]});
    else passed++;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      reset_i       = ($urandom_range(0, 63) == 0);
      id_rs1_i      = 5'($urandom_range(0, 3));
      id_rs2_i      = 5'($urandom_range(0, 3));
      ex_rd_i       = 5'($urandom_range(0, 3));
      id_rs1_used_i = 1'($urandom_range(0, 1));
      id_rs2_used_i = 1'($urandom_range(0, 1));
      ex_valid_i    = ($urandom_range(0, 3) != 0);
      ex_mem_read_i = 1'($urandom_range(0, 1));
      ex_redirect_i = ($urandom_range(0, 7) == 0);
      mem_busy_i    = ($urandom_range(0, 4) == 0);
      ex_target_i   = $urandom;
      cycle();
    end
    clear_inputs();
    cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_lu_x0();
    test_redirect();
    test_mem_busy();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
